// File: rtl/neural_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared MAC walks every weight of every
// neuron, then saturates and optionally ReLUs each neuron's sum into out_data.
module neural_layer_seq #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACT   = 0
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  w_we,
  input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]   w_addr,
  input  logic [DW-1:0]                         w_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_IN*DW-1:0]                    in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_OUT*DW-1:0]                   out_data
);

  localparam int NW    = N_IN*N_OUT + N_OUT;
  localparam int ADW   = $clog2(NW);
  localparam int AW    = 2*DW + $clog2(N_IN+1) + 1;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int BBASE = N_IN*N_OUT;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [JW-1:0]          j_q, j_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   mem_q [NW];
  logic signed [DW-1:0]   x_q   [N_IN];
  logic signed [DW-1:0]   out_q [N_OUT];
  logic signed [DW-1:0]   in_x  [N_IN];

  logic                   accept, wr_en, last_i, last_j, out_we;
  logic [ADW-1:0]         w_idx, b_idx;
  logic signed [DW-1:0]   bias0, bias_next, conv;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   sum, shifted;

  function automatic logic signed [AW-1:0] bias_ext(input logic signed [DW-1:0] b);
    return AW'(b) <<< FRAC;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign wr_en     = (state_q == S_IDLE) && w_we && ({1'b0, w_addr} < (ADW+1)'(NW));
  assign last_i    = (i_q == IW'(N_IN-1));
  assign last_j    = (j_q == JW'(N_OUT-1));
  assign out_we    = (state_q == S_RUN) && last_i;

  assign w_idx     = ADW'(32'(j_q)*N_IN + 32'(i_q));
  assign b_idx     = ADW'(BBASE + 32'(j_q) + 1);
  // A bias[0] write on the accept edge must already seed this run's accumulator.
  assign bias0     = (wr_en && w_addr == ADW'(BBASE)) ? w_data : mem_q[BBASE];
  assign bias_next = last_j ? '0 : mem_q[b_idx];

  assign prod      = mem_q[w_idx] * x_q[i_q];
  assign sum       = acc_q + AW'(prod);
  assign shifted   = sum >>> FRAC;

  always_comb begin
    conv = shifted[DW-1:0];
    if (shifted > MAXV)      conv = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < MINV) conv = {1'b1, {(DW-1){1'b0}}};
    if (ACT == 1 && conv[DW-1]) conv = '0;
  end

  genvar gi;
  for (gi = 0; gi < N_IN; gi++) begin : g_in
    assign in_x[gi] = in_data[gi*DW +: DW];
  end
  for (gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_data[gi*DW +: DW] = out_q[gi];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RUN;
        i_d     = '0;
        j_d     = '0;
        acc_d   = bias_ext(bias0);
      end
      S_RUN: if (last_i) begin
        i_d   = '0;
        acc_d = bias_ext(bias_next);
        if (last_j) begin
          state_d = S_DONE;
          j_d     = '0;
        end else begin
          j_d = j_q + JW'(1);
        end
      end else begin
        i_d   = i_q + IW'(1);
        acc_d = sum;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NW; k++)    mem_q[k] <= '0;
      for (int k = 0; k < N_IN; k++)  x_q[k]   <= '0;
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      for (int k = 0; k < NW; k++)
        if (wr_en && w_addr == ADW'(k)) mem_q[k] <= w_data;
      if (accept)
        for (int k = 0; k < N_IN; k++) x_q[k] <= in_x[k];
      for (int k = 0; k < N_OUT; k++)
        if (out_we && j_q == JW'(k)) out_q[k] <= conv;
    end
  end

endmodule

// File: tb/tb_neural_layer_seq.sv
// Bench for neural_layer_seq: 2x2 linear and ReLU instances in lockstep, plus a 4x3 ReLU
// instance checked against an arithmetic reference model with random weights and inputs.
module tb_neural_layer_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        a_we, a_in_valid, a_out_ready;
  logic [2:0]  a_addr;
  logic [15:0] a_wdata;
  logic [31:0] a_in_data;
  logic        lin_in_ready, lin_out_valid, relu_in_ready, relu_out_valid;
  logic [31:0] lin_out_data, relu_out_data;

  logic        b_we, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata;
  logic [63:0] b_in_data;
  logic [47:0] b_out_data;

  neural_layer_seq #(.N_IN(2), .N_OUT(2), .DW(16), .FRAC(8), .ACT(0)) u_lin (
    .CLK(CLK), .RST(RST), .w_we(a_we), .w_addr(a_addr), .w_data(a_wdata),
    .in_valid(a_in_valid), .in_ready(lin_in_ready), .in_data(a_in_data),
    .out_valid(lin_out_valid), .out_ready(a_out_ready), .out_data(lin_out_data));

  neural_layer_seq #(.N_IN(2), .N_OUT(2), .DW(16), .FRAC(8), .ACT(1)) u_relu (
    .CLK(CLK), .RST(RST), .w_we(a_we), .w_addr(a_addr), .w_data(a_wdata),
    .in_valid(a_in_valid), .in_ready(relu_in_ready), .in_data(a_in_data),
    .out_valid(relu_out_valid), .out_ready(a_out_ready), .out_data(relu_out_data));

  neural_layer_seq #(.N_IN(4), .N_OUT(3), .DW(16), .FRAC(8), .ACT(1)) u_big (
    .CLK(CLK), .RST(RST), .w_we(b_we), .w_addr(b_addr), .w_data(b_wdata),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference neuron: Q-format sum, floor shift, clamp, optional ReLU.
  function automatic logic [15:0] ref_neuron(input longint bias, input longint dot, input bit relu);
    longint v;
    v = (bias * 256 + dot) >>> 8;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return 16'(v);
  endfunction

  function automatic shortint rnd16();
    if ($urandom_range(0, 3) == 0) return shortint'($urandom);
    return shortint'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  task automatic a_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge CLK);
    a_we = 1'b1; a_addr = addr; a_wdata = data;
    @(negedge CLK);
    a_we = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [15:0] data);
    @(negedge CLK);
    b_we = 1'b1; b_addr = addr; b_wdata = data;
    @(negedge CLK);
    b_we = 1'b0;
  endtask

  // Presents one vector, then counts edges after the accept edge until out_valid.
  task automatic a_start(input logic [15:0] x0, input logic [15:0] x1, output int lat);
    @(negedge CLK);
    a_in_valid = 1'b1; a_in_data = {x1, x0};
    @(negedge CLK);
    a_in_valid = 1'b0;
    lat = 0;
    while (!lin_out_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic a_consume();
    a_out_ready = 1'b1;
    @(negedge CLK);
    a_out_ready = 1'b0;
  endtask

  typedef struct {
    string           name;
    logic [5:0][15:0] w;
    logic [15:0]     x0, x1;
    logic [31:0]     exp_lin, exp_relu;
  } vec_t;

  vec_t    vecs [6];
  int      lat;
  shortint aw [6];
  shortint ax [2];
  shortint bw [15];
  shortint bx [4];
  logic [31:0] exp_l, exp_r;
  logic [47:0] exp_b;

  initial begin
    a_we = 0; a_in_valid = 0; a_out_ready = 0; a_addr = 0; a_wdata = 0; a_in_data = 0;
    b_we = 0; b_in_valid = 0; b_out_ready = 0; b_addr = 0; b_wdata = 0; b_in_data = 0;

    vecs[0] = '{"zero",   {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                16'h0100, 16'h0100, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{"ident0", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100},
                16'h0100, 16'h0100, 32'h0000_0200, 32'h0000_0200};
    vecs[2] = '{"bias",   {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF},
                16'h0100, 16'h0100, 32'h0300_00FE, 32'h0300_00FE};
    vecs[3] = '{"relu",   {16'h0, 16'h0, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF},
                16'h0100, 16'h0100, 32'h0200_FFFE, 32'h0200_0000};
    vecs[4] = '{"satpos", {16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                16'h7FFF, 16'h7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF};
    vecs[5] = '{"satneg", {16'h0, 16'h0, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
                16'h7FFF, 16'h7FFF, 32'h8000_8000, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_out_valid", lin_out_valid, 0);
    check("rst_out_data", lin_out_data, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", lin_in_ready, 1);
    check("rst_big_in_ready", b_in_ready, 1);

    // No writes since reset: all-zero layer
    a_start(16'h0100, 16'h0100, lat);
    $display("txn fresh: lin=%h relu=%h lat=%0d", lin_out_data, relu_out_data, lat);
    check("fresh_lat", lat, 4);
    check("fresh_lin", lin_out_data, 32'h0);
    a_consume();

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 6; k++) a_write(3'(k), vecs[v].w[k]);
      a_start(vecs[v].x0, vecs[v].x1, lat);
      $display("txn %s: lin=%h relu=%h lat=%0d", vecs[v].name, lin_out_data, relu_out_data, lat);
      check({vecs[v].name, "_lat"}, lat, 4);
      check({vecs[v].name, "_lin"}, lin_out_data, vecs[v].exp_lin);
      check({vecs[v].name, "_relu"}, relu_out_data, vecs[v].exp_relu);
      a_consume();
    end

    // Stall in DONE: outputs hold, writes and new vectors ignored
    for (int k = 0; k < 6; k++) a_write(3'(k), vecs[1].w[k]);
    a_start(16'h0100, 16'h0100, lat);
    check("stall_lat", lat, 4);
    for (int c = 0; c < 10; c++) begin
      a_we = 1'b1; a_addr = 3'd0; a_wdata = 16'h1234;
      a_in_valid = 1'b1; a_in_data = {16'h7FFF, 16'h7FFF};
      check("stall_valid", lin_out_valid, 1);
      check("stall_data", lin_out_data, 32'h0000_0200);
      check("stall_in_ready", lin_in_ready, 0);
      @(negedge CLK);
    end
    a_we = 1'b0; a_in_valid = 1'b0;
    a_consume();
    $display("txn stall_release: in_ready=%b out_valid=%b", lin_in_ready, lin_out_valid);
    check("release_in_ready", lin_in_ready, 1);
    check("release_out_valid", lin_out_valid, 0);
    a_start(16'h0100, 16'h0100, lat);
    $display("txn post_stall: lin=%h lat=%0d", lin_out_data, lat);
    check("ignored_write", lin_out_data, 32'h0000_0200);
    a_consume();

    // out_ready already high when out_valid rises
    a_out_ready = 1'b1;
    a_start(16'h0100, 16'h0100, lat);
    check("early_ready_lat", lat, 4);
    check("no_bypass", lin_in_ready, 0);
    @(negedge CLK);
    $display("txn early_ready: in_ready=%b out_valid=%b", lin_in_ready, lin_out_valid);
    check("early_ready_idle", lin_in_ready, 1);
    a_out_ready = 1'b0;

    // Write to bias[0] on the accept edge is seen by that run
    @(negedge CLK);
    a_we = 1'b1; a_addr = 3'd4; a_wdata = 16'h0100;
    a_in_valid = 1'b1; a_in_data = {16'h0100, 16'h0100};
    @(negedge CLK);
    a_we = 1'b0; a_in_valid = 1'b0;
    lat = 0;
    while (!lin_out_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    $display("txn same_edge: lin=%h lat=%0d", lin_out_data, lat);
    check("same_edge_lat", lat, 4);
    check("same_edge_data", lin_out_data, 32'h0000_0300);
    a_consume();

    // Out-of-range addresses have no effect
    a_write(3'd6, 16'h7FFF);
    a_write(3'd7, 16'h8000);
    a_start(16'h0100, 16'h0100, lat);
    $display("txn oob_write: lin=%h", lin_out_data);
    check("oob_write", lin_out_data, 32'h0000_0300);
    a_consume();

    // Reset in the middle of a run
    @(negedge CLK);
    a_in_valid = 1'b1; a_in_data = {16'h0100, 16'h0100};
    @(negedge CLK);
    a_in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    $display("txn mid_reset: lin=%h valid=%b", lin_out_data, lin_out_valid);
    check("midrst_valid", lin_out_valid, 0);
    check("midrst_data", lin_out_data, 0);
    check("midrst_relu_data", relu_out_data, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_in_ready", lin_in_ready, 1);
    a_start(16'h0100, 16'h0100, lat);
    check("midrst_lat", lat, 4);
    check("midrst_weights_cleared", lin_out_data, 0);
    a_consume();

    // Random 2x2 vectors against the reference model
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 6; k++) begin
        aw[k] = rnd16();
        a_write(3'(k), 16'(aw[k]));
      end
      ax[0] = rnd16(); ax[1] = rnd16();
      for (int j = 0; j < 2; j++) begin
        longint dot;
        dot = longint'(aw[2*j]) * longint'(ax[0]) + longint'(aw[2*j+1]) * longint'(ax[1]);
        exp_l[16*j +: 16] = ref_neuron(longint'(aw[4+j]), dot, 1'b0);
        exp_r[16*j +: 16] = ref_neuron(longint'(aw[4+j]), dot, 1'b1);
      end
      a_start(16'(ax[0]), 16'(ax[1]), lat);
      $display("txn rand2x2 %0d: lin=%h relu=%h lat=%0d", t, lin_out_data, relu_out_data, lat);
      check("rand2_lat", lat, 4);
      check("rand2_lin", lin_out_data, exp_l);
      check("rand2_relu", relu_out_data, exp_r);
      a_consume();
    end

    // Random 4x3 ReLU layer against the reference model
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 15; k++) begin
        bw[k] = rnd16();
        b_write(4'(k), 16'(bw[k]));
      end
      for (int i = 0; i < 4; i++) bx[i] = rnd16();
      for (int j = 0; j < 3; j++) begin
        longint dot;
        dot = 0;
        for (int i = 0; i < 4; i++) dot += longint'(bw[4*j+i]) * longint'(bx[i]);
        exp_b[16*j +: 16] = ref_neuron(longint'(bw[12+j]), dot, 1'b1);
      end
      @(negedge CLK);
      check("big_in_ready", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_in_data = {16'(bx[3]), 16'(bx[2]), 16'(bx[1]), 16'(bx[0])};
      @(negedge CLK);
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 100) begin
        @(negedge CLK);
        lat++;
      end
      $display("txn rand4x3 %0d: out=%h exp=%h lat=%0d", t, b_out_data, exp_b, lat);
      check("big_lat", lat, 12);
      check("big_data", b_out_data, exp_b);
      b_out_ready = 1'b1;
      @(negedge CLK);
      b_out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
